// File: rtl/pa_pkg.sv
// Shared types and constants for the destination requantize/write path.
package pa_pkg;

    localparam int unsigned ACC_W       = 32;
    localparam int unsigned OUT_W       = 8;
    localparam int unsigned PIPE_STAGES = 4;
    localparam int unsigned PIPE_CNT_W  = $clog2(PIPE_STAGES + 1);

    // Rounding bias for the Q31 high-half extraction.
    localparam logic [63:0] Q31_ROUND = 64'h0000_0000_4000_0000;

    localparam logic [ACC_W-1:0] INT32_MIN = 32'h8000_0000;
    localparam logic [ACC_W-1:0] INT32_MAX = 32'h7FFF_FFFF;

    // One memory write: word address, packed bytes, byte enables.
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } word_entry_t;

    // Signed clamp of a 32-bit value into [lo, hi], returned as a byte.
    function automatic logic [OUT_W-1:0] clamp_int8(input logic [ACC_W-1:0] o,
                                                    input logic [OUT_W-1:0] lo,
                                                    input logic [OUT_W-1:0] hi);
        logic signed [ACC_W-1:0] lo_ext;
        logic signed [ACC_W-1:0] hi_ext;
        logic        [ACC_W-1:0] res;
        lo_ext = $signed({{(ACC_W - OUT_W){lo[OUT_W-1]}}, lo});
        hi_ext = $signed({{(ACC_W - OUT_W){hi[OUT_W-1]}}, hi});
        res    = o;
        if ($signed(o) > hi_ext) begin
            res = hi_ext;
        end else if ($signed(o) < lo_ext) begin
            res = lo_ext;
        end
        return res[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/pa_requant_pipe.sv
// Four-stage requantization pipeline: bias, Q31 multiply, rounding shift, offset+clamp.
module pa_requant_pipe
    import pa_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    input  logic [ACC_W-1:0]      acc_i,
    input  logic [ACC_W-1:0]      bias_i,
    input  logic [ACC_W-1:0]      multi_i,
    input  logic [ACC_W-1:0]      shift_i,
    input  logic [ACC_W-1:0]      offset_i,
    input  logic [OUT_W-1:0]      act_min_i,
    input  logic [OUT_W-1:0]      act_max_i,
    input  logic [31:0]           addr_i,
    output logic                  out_valid_o,
    output logic [OUT_W-1:0]      out_byte_o,
    output logic [31:0]           out_addr_o,
    output logic [PIPE_CNT_W-1:0] valid_count_o
);

    // S1 state
    logic             s1_valid_q;
    logic [ACC_W-1:0] s1_v_q, s1_v_d;
    logic [5:0]       s1_ls_q, s1_ls_d;
    logic [4:0]       s1_rs_q, s1_rs_d;
    logic [ACC_W-1:0] s1_multi_q, s1_offset_q;
    logic [OUT_W-1:0] s1_min_q, s1_max_q;
    logic [31:0]      s1_addr_q;
    // S2 state
    logic             s2_valid_q;
    logic [ACC_W-1:0] s2_h_q, s2_h_d;
    logic [4:0]       s2_rs_q;
    logic [ACC_W-1:0] s2_offset_q;
    logic [OUT_W-1:0] s2_min_q, s2_max_q;
    logic [31:0]      s2_addr_q;
    // S3 state
    logic             s3_valid_q;
    logic [ACC_W-1:0] s3_q_q, s3_q_d;
    logic [ACC_W-1:0] s3_offset_q;
    logic [OUT_W-1:0] s3_min_q, s3_max_q;
    logic [31:0]      s3_addr_q;
    // S4 state
    logic             s4_valid_q;
    logic [OUT_W-1:0] s4_byte_q, s4_byte_d;
    logic [31:0]      s4_addr_q;

    logic [ACC_W-1:0]        shift_neg;
    logic [ACC_W-1:0]        s2_a;
    logic signed [63:0]      s2_prod;
    logic [63:0]             s2_rounded;
    logic [ACC_W-1:0]        s3_mask, s3_rem, s3_thr, s3_shifted;
    logic [ACC_W-1:0]        s4_o;
    logic                    unused_bits;

    // S1: bias add and split of the signed shift into left/right amounts.
    always_comb begin
        s1_v_d    = acc_i + bias_i;
        s1_ls_d   = '0;
        s1_rs_d   = '0;
        shift_neg = '0 - shift_i;
        if ($signed(shift_i) > 32'sd0) begin
            s1_ls_d = ($signed(shift_i) >= 32'sd32) ? 6'd32 : shift_i[5:0];
        end else if ($signed(shift_i) < -32'sd31) begin
            s1_rs_d = 5'd31;
        end else begin
            s1_rs_d = shift_neg[4:0];
        end
    end

    // S2: left shift, Q31 multiply with round-half-up, saturate the one overflow case.
    always_comb begin
        s2_a       = s1_v_q << s1_ls_q;
        s2_prod    = $signed({{32{s2_a[31]}}, s2_a}) *
                     $signed({{32{s1_multi_q[31]}}, s1_multi_q});
        s2_rounded = s2_prod + Q31_ROUND;
        if (s2_a == INT32_MIN && s1_multi_q == INT32_MIN) begin
            s2_h_d = INT32_MAX;
        end else begin
            s2_h_d = s2_rounded[62:31];
        end
    end

    // S3: rounding arithmetic right shift; ties round away from zero.
    always_comb begin
        s3_mask    = (32'd1 << s2_rs_q) - 32'd1;
        s3_rem     = s2_h_q & s3_mask;
        s3_thr     = (s3_mask >> 1) + {31'd0, s2_h_q[31]};
        s3_shifted = $signed(s2_h_q) >>> s2_rs_q;
        s3_q_d     = s3_shifted + {31'd0, (s3_rem > s3_thr)};
    end

    // S4: output zero-point and activation clamp.
    always_comb begin
        s4_o      = s3_q_q + s3_offset_q;
        s4_byte_d = clamp_int8(s4_o, s3_min_q, s3_max_q);
    end

    assign unused_bits = ^{shift_neg[31:5], s2_rounded[63], s2_rounded[30:0]};

    // Stage registers with valid and address sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_v_q      <= '0;
            s1_ls_q     <= '0;
            s1_rs_q     <= '0;
            s1_multi_q  <= '0;
            s1_offset_q <= '0;
            s1_min_q    <= '0;
            s1_max_q    <= '0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_h_q      <= '0;
            s2_rs_q     <= '0;
            s2_offset_q <= '0;
            s2_min_q    <= '0;
            s2_max_q    <= '0;
            s2_addr_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_q_q      <= '0;
            s3_offset_q <= '0;
            s3_min_q    <= '0;
            s3_max_q    <= '0;
            s3_addr_q   <= '0;
            s4_valid_q  <= 1'b0;
            s4_byte_q   <= '0;
            s4_addr_q   <= '0;
        end else begin
            s1_valid_q  <= in_valid_i;
            s1_v_q      <= s1_v_d;
            s1_ls_q     <= s1_ls_d;
            s1_rs_q     <= s1_rs_d;
            s1_multi_q  <= multi_i;
            s1_offset_q <= offset_i;
            s1_min_q    <= act_min_i;
            s1_max_q    <= act_max_i;
            s1_addr_q   <= addr_i;
            s2_valid_q  <= s1_valid_q;
            s2_h_q      <= s2_h_d;
            s2_rs_q     <= s1_rs_q;
            s2_offset_q <= s1_offset_q;
            s2_min_q    <= s1_min_q;
            s2_max_q    <= s1_max_q;
            s2_addr_q   <= s1_addr_q;
            s3_valid_q  <= s2_valid_q;
            s3_q_q      <= s3_q_d;
            s3_offset_q <= s2_offset_q;
            s3_min_q    <= s2_min_q;
            s3_max_q    <= s2_max_q;
            s3_addr_q   <= s2_addr_q;
            s4_valid_q  <= s3_valid_q;
            s4_byte_q   <= s4_byte_d;
            s4_addr_q   <= s3_addr_q;
        end
    end

    assign out_valid_o   = s4_valid_q;
    assign out_byte_o    = s4_byte_q;
    assign out_addr_o    = s4_addr_q;
    assign valid_count_o = PIPE_CNT_W'(s1_valid_q) + PIPE_CNT_W'(s2_valid_q) +
                           PIPE_CNT_W'(s3_valid_q) + PIPE_CNT_W'(s4_valid_q);

endmodule

// File: rtl/pa_dst_requant_wr.sv
// Requantize accumulator results, pack bytes into strobed words, queue them to memory.
module pa_dst_requant_wr
    import pa_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dst_wr_rdy,
    output logic        dst_wr_acq,
    input  logic [31:0] result_data,
    input  logic [31:0] dst_addr,
    input  logic [31:0] bias,
    input  logic [31:0] dst_multi,
    input  logic [31:0] dst_shift,
    input  logic [31:0] out_offset,
    input  logic [7:0]  act_min,
    input  logic [7:0]  act_max,
    input  logic        flush,
    output logic        mem_wr_req,
    input  logic        mem_wr_gnt,
    output logic [29:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_strb,
    output logic        busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic                  ready_q;
    logic                  accept;
    logic [31:0]           occupancy;

    logic                  byte_valid;
    logic [OUT_W-1:0]      byte_data;
    logic [31:0]           byte_addr;
    logic [1:0]            byte_lane;
    logic [PIPE_CNT_W-1:0] pipe_count;

    logic [29:0]           pk_addr_q, pk_addr_d;
    logic [31:0]           pk_data_q, pk_data_d;
    logic [3:0]            pk_strb_q, pk_strb_d;
    logic                  pk_done_q, pk_done_d;
    logic                  pk_nonempty;
    logic                  flush_pend_q, flush_pend_d;
    logic                  evict;
    logic [31:0]           base_data, merged_data;
    logic [3:0]            base_strb, merged_strb;

    word_entry_t           push_entry;
    word_entry_t           head;
    word_entry_t           fifo_mem_q [FIFO_DEPTH];
    logic                  fifo_push, fifo_pop;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       fifo_count_q, fifo_count_d;

    pa_requant_pipe u_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (accept),
        .acc_i         (result_data),
        .bias_i        (bias),
        .multi_i       (dst_multi),
        .shift_i       (dst_shift),
        .offset_i      (out_offset),
        .act_min_i     (act_min),
        .act_max_i     (act_max),
        .addr_i        (dst_addr),
        .out_valid_o   (byte_valid),
        .out_byte_o    (byte_data),
        .out_addr_o    (byte_addr),
        .valid_count_o (pipe_count)
    );

    // Credit: every element in flight already owns a FIFO slot, so the pipe never stalls.
    always_comb begin
        occupancy  = 32'(fifo_count_q) + 32'(pipe_count) + 32'(pk_nonempty);
        dst_wr_acq = ready_q && (occupancy < FIFO_DEPTH);
        accept     = dst_wr_rdy && dst_wr_acq;
    end

    assign pk_nonempty = (pk_strb_q != 4'd0);
    assign byte_lane   = byte_addr[1:0];

    // Packer: merge bytes into the open word, push on lane 3, address change or flush.
    always_comb begin
        pk_addr_d    = pk_addr_q;
        pk_data_d    = pk_data_q;
        pk_strb_d    = pk_strb_q;
        pk_done_d    = pk_done_q;
        flush_pend_d = flush_pend_q | flush;
        fifo_push    = 1'b0;
        push_entry   = '0;
        evict        = 1'b0;
        base_data    = pk_data_q;
        base_strb    = pk_strb_q;
        merged_data  = '0;
        merged_strb  = '0;
        if (byte_valid) begin
            evict = pk_nonempty && ((byte_addr[31:2] != pk_addr_q) || pk_done_q);
            if (evict) begin
                fifo_push  = 1'b1;
                push_entry = '{addr: pk_addr_q, data: pk_data_q, strb: pk_strb_q};
                base_data  = '0;
                base_strb  = '0;
            end
            merged_data = base_data;
            merged_data[{byte_lane, 3'b000} +: 8] = byte_data;
            merged_strb = base_strb | (4'b0001 << byte_lane);
            if (byte_lane == 2'd3 && !evict) begin
                fifo_push  = 1'b1;
                push_entry = '{addr: byte_addr[31:2], data: merged_data, strb: merged_strb};
                pk_data_d  = '0;
                pk_strb_d  = '0;
                pk_done_d  = 1'b0;
            end else begin
                // A completed word behind an eviction waits one cycle for the push port.
                pk_addr_d = byte_addr[31:2];
                pk_data_d = merged_data;
                pk_strb_d = merged_strb;
                pk_done_d = (byte_lane == 2'd3);
            end
        end else if (pk_nonempty &&
                     (pk_done_q || (flush_pend_q && pipe_count == '0))) begin
            fifo_push  = 1'b1;
            push_entry = '{addr: pk_addr_q, data: pk_data_q, strb: pk_strb_q};
            pk_data_d  = '0;
            pk_strb_d  = '0;
            pk_done_d  = 1'b0;
        end
        if (flush_pend_q && pipe_count == '0) begin
            flush_pend_d = flush;
        end
    end

    // FIFO pointers and occupancy.
    always_comb begin
        fifo_pop     = mem_wr_req && mem_wr_gnt;
        wr_ptr_d     = fifo_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d     = fifo_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        fifo_count_d = fifo_count_q + CntW'(fifo_push) - CntW'(fifo_pop);
    end

    // Control state: credit enable, packer, flush request, FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            pk_addr_q    <= '0;
            pk_data_q    <= '0;
            pk_strb_q    <= '0;
            pk_done_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            ready_q      <= 1'b1;
            pk_addr_q    <= pk_addr_d;
            pk_data_q    <= pk_data_d;
            pk_strb_q    <= pk_strb_d;
            pk_done_q    <= pk_done_d;
            flush_pend_q <= flush_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Memory port driven from the FIFO head; fields read as zero when nothing is queued.
    always_comb begin
        head        = fifo_mem_q[rd_ptr_q];
        mem_wr_req  = (fifo_count_q != '0);
        mem_wr_addr = mem_wr_req ? head.addr : '0;
        mem_wr_data = mem_wr_req ? head.data : '0;
        mem_wr_strb = mem_wr_req ? head.strb : '0;
        busy        = (pipe_count != '0) || pk_nonempty || (fifo_count_q != '0) ||
                      flush_pend_q;
    end

endmodule

// File: tb/tb_pa_dst_requant_wr.sv
// Directed bench for pa_dst_requant_wr.
module tb_pa_dst_requant_wr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dst_wr_rdy;
    logic        dst_wr_acq;
    logic [31:0] result_data, dst_addr, bias, dst_multi, dst_shift, out_offset;
    logic [7:0]  act_min, act_max;
    logic        flush;
    logic        mem_wr_req, mem_wr_gnt;
    logic [29:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int bp_acc, bp_wr, cyc, req_seen;
    bit took;

    always #5 clk = ~clk;

    pa_dst_requant_wr #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dst_wr_rdy  (dst_wr_rdy),
        .dst_wr_acq  (dst_wr_acq),
        .result_data (result_data),
        .dst_addr    (dst_addr),
        .bias        (bias),
        .dst_multi   (dst_multi),
        .dst_shift   (dst_shift),
        .out_offset  (out_offset),
        .act_min     (act_min),
        .act_max     (act_max),
        .flush       (flush),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_gnt  (mem_wr_gnt),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_strb (mem_wr_strb),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] acc, input logic [31:0] b, input logic [31:0] m,
                          input logic [31:0] sh, input logic [31:0] off, input logic [31:0] addr);
        result_data = acc;
        bias        = b;
        dst_multi   = m;
        dst_shift   = sh;
        out_offset  = off;
        act_min     = 8'h80;
        act_max     = 8'h7F;
        dst_addr    = addr;
    endtask

    // Hold rdy until accepted (bounded); returns at posedge+1 of the next cycle.
    task automatic offer(input logic [31:0] acc, input logic [31:0] b, input logic [31:0] m,
                         input logic [31:0] sh, input logic [31:0] off, input logic [31:0] addr);
        int n = 0;
        bit ok = 1'b0;
        set_in(acc, b, m, sh, off, addr);
        dst_wr_rdy = 1'b1;
        while (n < 50 && !ok) begin
            @(negedge clk);
            if (dst_wr_acq) ok = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        dst_wr_rdy = 1'b0;
        chk("offer_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_word(input string tag, input logic [29:0] ea, input logic [31:0] ed,
                             input logic [3:0] es);
        int n = 0;
        bit seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            if (mem_wr_req && mem_wr_gnt) begin
                seen = 1'b1;
                chk({tag, "_addr"}, 64'(mem_wr_addr), 64'(ea));
                chk({tag, "_data"}, 64'(mem_wr_data), 64'(ed));
                chk({tag, "_strb"}, 64'(mem_wr_strb), 64'(es));
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic set_bp(input int i);
        set_in(32'(i + 1), 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'h300 + 32'(4 * i) + 32'd3);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_acq"},  64'(dst_wr_acq),  64'd0);
        chk({tag, "_req"},  64'(mem_wr_req),  64'd0);
        chk({tag, "_addr"}, 64'(mem_wr_addr), 64'd0);
        chk({tag, "_data"}, 64'(mem_wr_data), 64'd0);
        chk({tag, "_strb"}, 64'(mem_wr_strb), 64'd0);
        chk({tag, "_busy"}, 64'(busy),        64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        dst_wr_rdy = 1'b0;
        flush      = 1'b0;
        mem_wr_gnt = 1'b0;
        set_in(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_reset_acq", 64'(dst_wr_acq), 64'd1);
        @(posedge clk);
        #1;

        // Four bytes of -103 into one word; request appears 5 cycles after the last accept.
        mem_wr_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'd100, 32'd0, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h40 + 32'(i));
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_req_timing", 64'(mem_wr_req), (k == 5) ? 64'd1 : 64'd0);
            if (k == 5) begin
                chk("t1_addr", 64'(mem_wr_addr), 64'h10);
                chk("t1_data", 64'(mem_wr_data), 64'h9999_9999);
                chk("t1_strb", 64'(mem_wr_strb), 64'hF);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t1_req_after_pop", 64'(mem_wr_req), 64'd0);
        chk("t1_busy_after_pop", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Rounding thresholds (-3->-2, 3->2, 5->1) and the saturating product (-> 127).
        mem_wr_gnt = 1'b0;
        offer(32'hFFFF_FFFD, 32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h200);
        offer(32'd3,         32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h201);
        offer(32'd5,         32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'h202);
        offer(32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd0,         32'd0, 32'h203);
        mem_wr_gnt = 1'b1;
        wait_word("round", 30'h80, 32'h7F01_02FE, 4'hF);

        // Six bytes then flush: one full word and one partial word.
        mem_wr_gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            offer(32'(i + 1), 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'h100 + 32'(i));
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        mem_wr_gnt = 1'b1;
        wait_word("flush_w0", 30'h40, 32'h0403_0201, 4'hF);
        wait_word("flush_w1", 30'h41, 32'h0000_0605, 4'h3);
        @(negedge clk);
        chk("flush_busy_low", 64'(busy), 64'd0);
        chk("flush_req_low", 64'(mem_wr_req), 64'd0);
        @(posedge clk);
        #1;

        // Back-pressure: credit caps acceptance at the FIFO depth, then all 16 drain in order.
        mem_wr_gnt = 1'b0;
        bp_acc = 0;
        bp_wr  = 0;
        set_bp(0);
        dst_wr_rdy = 1'b1;
        repeat (20) begin
            @(negedge clk);
            took = dst_wr_rdy && dst_wr_acq;
            @(posedge clk);
            #1;
            if (took) begin
                bp_acc++;
                if (bp_acc < 16) set_bp(bp_acc);
                else dst_wr_rdy = 1'b0;
            end
        end
        chk("bp_accepts_held", 64'(bp_acc), 64'd4);
        chk("bp_acq_low", 64'(dst_wr_acq), 64'd0);
        chk("bp_req_held", 64'(mem_wr_req), 64'd1);
        mem_wr_gnt = 1'b1;
        cyc = 0;
        while ((bp_acc < 16 || bp_wr < 16) && cyc < 400) begin
            @(negedge clk);
            took = dst_wr_rdy && dst_wr_acq;
            if (mem_wr_req && mem_wr_gnt) begin
                chk("bp_addr", 64'(mem_wr_addr), 64'(30'hC0 + 30'(bp_wr)));
                chk("bp_data", 64'({mem_wr_data, mem_wr_strb}),
                    64'({32'(bp_wr + 1) << 24, 4'h8}));
                bp_wr++;
            end
            @(posedge clk);
            #1;
            if (took) begin
                bp_acc++;
                if (bp_acc < 16) set_bp(bp_acc);
                else dst_wr_rdy = 1'b0;
            end
            cyc++;
        end
        dst_wr_rdy = 1'b0;
        chk("bp_total_accepts", 64'(bp_acc), 64'd16);
        chk("bp_total_words", 64'(bp_wr), 64'd16);

        // Mid-flight reset discards everything.
        mem_wr_gnt = 1'b0;
        offer(32'd9, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'h403);
        offer(32'd8, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'h407);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        mem_wr_gnt = 1'b1;
        req_seen   = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_wr_req) req_seen++;
            @(posedge clk);
            #1;
        end
        chk("midreset_no_req", 64'(req_seen), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_acq_back", 64'(dst_wr_acq), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pa_dst_requant_wr.md
Name: pa_dst_requant_wr

Overview:
- Downstream of the processing-array controller: consumes the 16 int32 accumulators per output tile over the dst_wr_rdy/dst_wr_acq handshake.
- Adds bias, requantizes with dst_multi/dst_shift, adds the output offset, clamps to int8.
- Packs bytes into 32-bit words with byte strobes and pushes them through an output FIFO to the memory write port.

Parameters:
FIFO_DEPTH, 4, output word FIFO entries; power of two, >=2
PIPE_STAGES, 4, requant pipeline depth; fixed at 4, listed for the package constant

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dst_wr_rdy  in  1  controller offers a result
dst_wr_acq  out  1  block accepts; transfer when rdy&acq
result_data  in  32  signed accumulator at current result_addr
dst_addr  in  32  byte address of the output element (controller mem_bias_addr)
bias  in  32  signed per-channel bias
dst_multi  in  32  signed Q31 multiplier
dst_shift  in  32  signed shift; >0 left, <0 right
out_offset  in  32  signed output zero-point
act_min  in  8  signed clamp low
act_max  in  8  signed clamp high
flush  in  1  pulse at tile end: emit partial word
mem_wr_req  out  1  word valid
mem_wr_gnt  in  1  memory takes word when req&gnt
mem_wr_addr  out  30  word address (dst_addr[31:2])
mem_wr_data  out  32  packed bytes, lane n = bits 8n+7:8n
mem_wr_strb  out  4  byte enables
busy  out  1  any element or word in flight

Behaviour:
- Reset: dst_wr_acq=0, mem_wr_req=0, mem_wr_addr/data/strb=0, busy=0; pipeline valids, packer, FIFO and flush_pend cleared. A mid-operation reset discards all in-flight data.
- Credit: dst_wr_acq = (fifo_count + pipe_valid_count + packer_nonempty) < FIFO_DEPTH. It is independent of dst_wr_rdy, so no pipeline stall is ever needed.
- Accept cycle T: result_data, bias, dst_multi, dst_shift, out_offset, act_min, act_max and dst_addr are captured together.
- S1: v = acc + bias, 32-bit wrap. ls = max(shift,0), rs = max(-shift,0) (rs limited to 0..31).
- S2: a = v << ls (32-bit wrap). p = a*dst_multi, 64-bit signed. If a == dst_multi == 0x80000000, h = 0x7FFFFFFF; else h = (p + 2^30) >>> 31.
- S3: rounding divide by 2^rs: q = (h >>> rs) + (rem > thr). rem = h & (2^rs-1), thr = ((2^rs-1)>>1) + (h<0).
- S4: o = q + out_offset (32-bit), clamped to [act_min, act_max] sign-extended, truncated to 8 bits. The byte is valid to the packer at T+4.
- Packer holds the current word address W and strobe S:
  - Incoming byte with addr[31:2] != W while S != 0: push {W,data,S} first, then start a new word.
  - Write byte into lane addr[1:0] and set its strobe bit.
  - If lane == 3, push the word at the next edge (FIFO visible T+5 earliest; mem_wr_req high at T+5).
  - A repeated lane in the same word overwrites the byte (last wins).
- Flush: sets flush_pend. When the pipeline is empty and flush_pend=1, a nonzero S is pushed as a partial word, then flush_pend clears. With S=0 it just clears.
- FIFO: mem_wr_* driven from the FIFO head; pop on req&gnt. Simultaneous push and pop keeps the count. Push into a full FIFO cannot occur (credit); assertion in bench.
- busy = any pipe valid | packer nonempty | fifo_count != 0 | flush_pend.

Decomposition:
- Package pa_pkg: ACC_W=32, OUT_W=8, Q31 rounding constant 2^30, INT32_MIN/MAX, word-entry struct {addr[29:0], data[31:0], strb[3:0]}.
- One sub-module pa_requant_pipe: stages S1-S4 with valid and address sideband.
- Packer, FIFO and credit logic stay in the top.

Test Plan:
- acc=100, bias=0, multi=0x40000000, shift=-1, offset=-128, min=-128, max=127, addr=0x40 -> byte 0x99 (-103). Accept 4 at 0x40..0x43 -> one write addr=0x10, strb=0xF, 5 cycles after the last accept.
- acc=0x7FFFFFFF, bias=1, multi=0x80000000, shift=0 -> v=0x80000000, saturating product 0x7FFFFFFF -> clamp to 127 (0x7F).
- h=-3, shift=-1 -> -2; h=3, shift=-1 -> 2; h=5, shift=-2 -> 1 (checks rounding thresholds).
- 6 elements at addr 0x100..0x105, then flush -> words {0x40, strb 0xF} and {0x41, strb 0x3}; busy falls after the last grant.
- mem_wr_gnt held low with 16 rdy offers -> acq drops once credit reaches FIFO_DEPTH=4, no loss. Releasing gnt delivers words in order.
- Assert rst_n low with 2 elements in flight -> all outputs 0 next cycle, no mem_wr_req after release.
